// File: rtl/lockout_timer_pkg.sv
// Shared definitions for the authentication lockout path: state encodings,
// the blank-digit code understood by seven_seg, and two-digit BCD helpers.
package lockout_timer_pkg;

    localparam logic [1:0] ST_IDLE   = 2'b01;
    localparam logic [1:0] ST_LOCKED = 2'b10;

    localparam logic [3:0] BCD_BLANK = 4'hF;

    function automatic logic [7:0] to_bcd2(input int unsigned value);
        to_bcd2 = {4'(value / 32'd10), 4'(value % 32'd10)};
    endfunction

    // Saturates at 00 so the tens digit can never underflow.
    function automatic logic [7:0] bcd2_dec(input logic [7:0] digits);
        if (digits[3:0] != 4'd0) begin
            bcd2_dec = {digits[7:4], digits[3:0] - 4'd1};
        end else if (digits[7:4] != 4'd0) begin
            bcd2_dec = {digits[7:4] - 4'd1, 4'd9};
        end else begin
            bcd2_dec = digits;
        end
    endfunction

endpackage

// File: rtl/lockout_timer_bcd_down_counter.sv
// Two-digit BCD down counter with synchronous load; load wins over decrement.
module bcd_down_counter
    import lockout_timer_pkg::*;
#(
    parameter logic [7:0] RST_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       dec,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       zero
);

    logic [7:0] digits_q;
    logic [7:0] digits_d;

    always_comb begin
        digits_d = digits_q;
        if (load) begin
            digits_d = load_val;
        end else if (dec) begin
            digits_d = bcd2_dec(digits_q);
        end else begin
            digits_d = digits_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digits_q <= RST_VAL;
        end else begin
            digits_q <= digits_d;
        end
    end

    assign tens = digits_q[7:4];
    assign ones = digits_q[3:0];
    assign zero = (digits_q == 8'h00);

endmodule

// File: rtl/lockout_timer.sv
// Failed-attempt tracker and lockout countdown. The digit counter doubles as
// the display register: in IDLE it is reloaded every cycle with blank/attempts-left.
module lockout_timer
    import lockout_timer_pkg::*;
#(
    parameter int MAX_FAILS = 3,
    parameter int LOCK_SECS = 30,
    parameter int TICK_DIV  = 10_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       auth_fail,
    input  logic       auth_pass,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_ones,
    output logic       locked,
    output logic       lock_done
);

    localparam int             PW       = $clog2(TICK_DIV);
    localparam logic [PW-1:0]  TERM     = PW'(TICK_DIV - 1);
    localparam logic [3:0]     MAX_F    = 4'(MAX_FAILS);
    localparam logic [7:0]     LOCK_BCD = to_bcd2(LOCK_SECS);

    if (MAX_FAILS < 1 || MAX_FAILS > 9) begin : g_bad_max_fails
        $fatal(1, "lockout_timer: MAX_FAILS out of range 1..9");
    end
    if (LOCK_SECS < 1 || LOCK_SECS > 99) begin : g_bad_lock_secs
        $fatal(1, "lockout_timer: LOCK_SECS out of range 1..99");
    end
    if (TICK_DIV < 2) begin : g_bad_tick_div
        $fatal(1, "lockout_timer: TICK_DIV must be at least 2");
    end

    logic [1:0]    state_q, state_d;
    logic [3:0]    fail_cnt_q, fail_cnt_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          locked_q, locked_d;
    logic          lock_done_q, lock_done_d;

    logic          load_s;
    logic          dec_s;
    logic          zero_s;
    logic [7:0]    load_val_s;

    always_comb begin
        state_d     = state_q;
        fail_cnt_d  = fail_cnt_q;
        presc_d     = presc_q;
        lock_done_d = 1'b0;
        load_s      = 1'b1;
        dec_s       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                presc_d = {PW{1'b0}};
                // A simultaneous pass is ignored: the fail branch takes priority.
                if (auth_fail) begin
                    fail_cnt_d = fail_cnt_q + 4'd1;
                    if (fail_cnt_q + 4'd1 == MAX_F) begin
                        state_d = ST_LOCKED;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (auth_pass) begin
                    fail_cnt_d = 4'd0;
                end else begin
                    fail_cnt_d = fail_cnt_q;
                end
            end
            ST_LOCKED: begin
                load_s = 1'b0;
                if (presc_q == TERM) begin
                    presc_d = {PW{1'b0}};
                    // 00 has been shown for a full tick by now, so this tick ends the lockout.
                    if (zero_s) begin
                        state_d     = ST_IDLE;
                        fail_cnt_d  = 4'd0;
                        lock_done_d = 1'b1;
                        load_s      = 1'b1;
                    end else begin
                        dec_s = 1'b1;
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            default: begin
                state_d    = ST_IDLE;
                fail_cnt_d = 4'd0;
                presc_d    = {PW{1'b0}};
            end
        endcase
        locked_d = (state_d == ST_LOCKED);
    end

    assign load_val_s = (state_d == ST_LOCKED) ? LOCK_BCD
                                               : {BCD_BLANK, MAX_F - fail_cnt_d};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            fail_cnt_q  <= 4'd0;
            presc_q     <= {PW{1'b0}};
            locked_q    <= 1'b0;
            lock_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fail_cnt_q  <= fail_cnt_d;
            presc_q     <= presc_d;
            locked_q    <= locked_d;
            lock_done_q <= lock_done_d;
        end
    end

    bcd_down_counter #(
        .RST_VAL ({BCD_BLANK, MAX_F})
    ) u_digits (
        .clk      (clk),
        .rst      (rst),
        .load     (load_s),
        .load_val (load_val_s),
        .dec      (dec_s),
        .tens     (bcd_tens),
        .ones     (bcd_ones),
        .zero     (zero_s)
    );

    assign locked    = locked_q;
    assign lock_done = lock_done_q;

endmodule

// File: tb/tb_lockout_timer.sv
// Directed bench for lockout_timer (MAX_FAILS=3, LOCK_SECS=12, TICK_DIV=4) with a
// behavioural reference model feeding a scoreboard queue.
module tb_lockout_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       auth_fail = 1'b0;
    logic       auth_pass = 1'b0;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_ones;
    logic       locked;
    logic       lock_done;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string      tag;
        logic [3:0] tens;
        logic [3:0] ones;
        logic       locked;
        logic       done;
    } exp_t;

    exp_t q[$];

    // Reference model: seconds kept as a plain integer, not BCD.
    bit m_locked;
    bit m_done;
    int m_fails;
    int m_secs;
    int m_presc;

    always #5 clk = ~clk;

    lockout_timer #(
        .MAX_FAILS (3),
        .LOCK_SECS (12),
        .TICK_DIV  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .auth_fail (auth_fail),
        .auth_pass (auth_pass),
        .bcd_tens  (bcd_tens),
        .bcd_ones  (bcd_ones),
        .locked    (locked),
        .lock_done (lock_done)
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        m_done   = 1'b0;
        m_fails  = 0;
        m_secs   = 0;
        m_presc  = 0;
    endtask

    task automatic model_step(input bit f, input bit p);
        m_done = 1'b0;
        if (!m_locked) begin
            if (f) begin
                m_fails++;
                if (m_fails == 3) begin
                    m_locked = 1'b1;
                    m_secs   = 12;
                    m_presc  = 0;
                end
            end else if (p) begin
                m_fails = 0;
            end
        end else if (m_presc == 3) begin
            m_presc = 0;
            if (m_secs == 0) begin
                m_locked = 1'b0;
                m_fails  = 0;
                m_done   = 1'b1;
            end else begin
                m_secs--;
            end
        end else begin
            m_presc++;
        end
    endtask

    function automatic exp_t model_out(input string tag);
        exp_t e;
        e.tag    = tag;
        e.tens   = m_locked ? 4'(m_secs / 10) : 4'hF;
        e.ones   = m_locked ? 4'(m_secs % 10) : 4'(3 - m_fails);
        e.locked = m_locked;
        e.done   = m_done;
        return e;
    endfunction

    task automatic cycle(input bit f, input bit p, input string tag);
        exp_t e;
        auth_fail = f;
        auth_pass = p;
        model_step(f, p);
        q.push_back(model_out(tag));
        @(posedge clk);
        #1;
        auth_fail = 1'b0;
        auth_pass = 1'b0;
        e = q.pop_front();
        chk({e.tag, ".tens"},   bcd_tens,        e.tens);
        chk({e.tag, ".ones"},   bcd_ones,        e.ones);
        chk({e.tag, ".locked"}, {3'b000, locked},    {3'b000, e.locked});
        chk({e.tag, ".done"},   {3'b000, lock_done}, {3'b000, e.done});
    endtask

    // Runs until lock_done is seen (bounded) and returns cycles since the locking edge.
    task automatic run_lock(input bit noise, input string tag, output int n);
        n = 100;
        for (int i = 1; i <= 100; i++) begin
            if (noise) begin
                cycle(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), tag);
            end else begin
                cycle(1'b0, 1'b0, tag);
            end
            if (lock_done === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".tens"},   bcd_tens, 4'hF);
        chk({tag, ".ones"},   bcd_ones, 4'h3);
        chk({tag, ".locked"}, {3'b000, locked},    4'h0);
        chk({tag, ".done"},   {3'b000, lock_done}, 4'h0);
    endtask

    initial begin
        int n;
        model_reset();

        // Reset asserted before the first clock edge: outputs must follow asynchronously.
        #2 rst = 1'b1;
        #1 chk_reset_state("rst_async");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        cycle(1'b1, 1'b0, "fail1");
        chk("fail1_ones_const", bcd_ones, 4'd2);
        cycle(1'b1, 1'b0, "fail2");
        chk("fail2_ones_const", bcd_ones, 4'd1);
        cycle(1'b0, 1'b1, "pass_clear");
        chk("pass_ones_const", bcd_ones, 4'd3);
        cycle(1'b0, 1'b0, "idle");

        cycle(1'b1, 1'b0, "s3_fail1");
        cycle(1'b1, 1'b0, "s3_fail2");
        cycle(1'b1, 1'b0, "s3_lock");
        chk("s3_lock_tens", bcd_tens, 4'd1);
        chk("s3_lock_ones", bcd_ones, 4'd2);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, "s3_count");
        chk("s3_after4_ones", bcd_ones, 4'd1);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, "s3_borrow");
        chk("s3_borrow_tens", bcd_tens, 4'd0);
        chk("s3_borrow_ones", bcd_ones, 4'd9);
        run_lock(1'b0, "s3_run", n);
        chk("s3_exit_cycles", 4'(n == 52 - 12 ? 1 : 0), 4'd1);
        chk("s3_exit_display_ones", bcd_ones, 4'd3);
        cycle(1'b0, 1'b0, "s3_after_exit");

        cycle(1'b1, 1'b0, "s4_fail1");
        cycle(1'b1, 1'b0, "s4_fail2");
        cycle(1'b1, 1'b1, "s4_both");
        chk("s4_locked", {3'b000, locked}, 4'h1);
        run_lock(1'b1, "s5_noise", n);
        chk("s5_exit_cycles", 4'(n == 52 ? 1 : 0), 4'd1);

        cycle(1'b1, 1'b0, "s6_fail1");
        cycle(1'b1, 1'b0, "s6_fail2");
        cycle(1'b1, 1'b0, "s6_lock");
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, "s6_count");
        chk("s6_pre_tens", bcd_tens, 4'd0);
        chk("s6_pre_ones", bcd_ones, 4'd7);
        #2 rst = 1'b1;
        #1 chk_reset_state("s6_rst_async");
        model_reset();
        #2 rst = 1'b0;
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, "s6_post_rst");
        cycle(1'b1, 1'b0, "s6_refail1");
        cycle(1'b1, 1'b0, "s6_refail2");
        cycle(1'b1, 1'b0, "s6_relock");
        chk("s6_relock_tens", bcd_tens, 4'd1);
        chk("s6_relock_ones", bcd_ones, 4'd2);
        run_lock(1'b0, "s6_run", n);
        chk("s6_exit_cycles", 4'(n == 52 ? 1 : 0), 4'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
